// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame/synchroniser constants.
// Also intended for the future hardware transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_SYNC_STAGES = 2;

endpackage

// File: rtl/sync2.sv
// Multi-flop synchroniser for asynchronous pad inputs.
// RESET_VAL sets the value it presents while in reset.
module sync2
    import uart_pkg::*;
#(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [UART_SYNC_STAGES-1:0] ff_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ff_q <= {UART_SYNC_STAGES{RESET_VAL}};
        else       ff_q <= {ff_q[UART_SYNC_STAGES-2:0], d_i};
    end

    assign q_o = ff_q[UART_SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with a one-byte holding register,
// sticky framing/overrun flags and registered active-low clear-to-send.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 347
) (
    input  logic       clk_core_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ack_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       err_clear_i,
    output logic       cts_n_o
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT + 1);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(CYCLES_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(CYCLES_PER_BIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      fe_q, fe_d;
    logic                      ov_q, ov_d;
    logic                      cts_n_q;
    logic                      rxs, rxs_prev_q;
    logic                      sample;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk_i (clk_core_i),
        .rst_i (reset_i),
        .d_i   (rx_i),
        .q_o   (rxs)
    );

    // Counter is loaded with N and the sample happens N cycles later, when it reads 1.
    assign sample = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = fe_q;
        ov_d    = ov_q;

        if (rx_ack_i && valid_q) valid_d = 1'b0;
        if (err_clear_i) begin
            fe_d = 1'b0;
            ov_d = 1'b0;
        end

        // Set events below are evaluated after the clears so they take priority.
        case (state_q)
            ST_IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    cnt_d   = HALF;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!sample) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = FULL;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!sample) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
                    cnt_d   = FULL;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (!sample) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs) begin
                    if (!valid_q || rx_ack_i) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ov_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    fe_d    = 1'b1;
                    state_d = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_core_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
            cts_n_q    <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fe_q       <= fe_d;
            ov_q       <= ov_d;
            cts_n_q    <= valid_d;
            rxs_prev_q <= rxs;
        end
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = fe_q;
    assign overrun_o   = ov_q;
    assign cts_n_o     = cts_n_q;

endmodule
